// File: rtl/reference_model.sv
// Register-access decoder for a DMA controller's CPU port, plus byte-pointer flip-flop.
// Optional macro TEMP_READ_EN enables the temporary-register read decode at A=1101.
module reference_model (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CS_N,
   input  logic       IOR_N,
   input  logic       IOW_N,
   input  logic [3:0] A,
   input  logic       programCondition,
   output logic       loadCommandReg,
   output logic       readStatusReg,
   output logic       loadRequestReg,
   output logic       loadMaskBit,
   output logic       loadModeReg,
   output logic       clearInternalFF,
   output logic       masterClear,
   output logic       readTemporaryReg,
   output logic       clearMaskReg,
   output logic       loadAllMask,
   output logic       loadBaseAddressReg,
   output logic       loadBaseWordCountReg,
   output logic       readCurrentAddressReg,
   output logic       readCurrentWordCountReg,
   output logic [1:0] channelSel,
   output logic       internalFF,
   output logic       loadIoDataBufferFromStatus,
   output logic       accessError
);

   logic selected;
   logic rd;
   logic wr;
   logic low_access;
   logic internal_ff_reg;
   logic access_seen_reg;
   logic status_read_reg;

   // Reset gates everything combinational so decodes are silent while RESET_N is low.
   assign selected    = programCondition & ~CS_N & RESET_N;
   assign rd          = selected & ~IOR_N &  IOW_N;
   assign wr          = selected & ~IOW_N &  IOR_N;
   assign accessError = selected & ~IOR_N & ~IOW_N;
   assign low_access  = (rd | wr) & ~A[3];
   assign channelSel  = A[3] ? 2'b00 : A[2:1];

   always_comb begin
      loadCommandReg          = 1'b0;
      readStatusReg           = 1'b0;
      loadRequestReg          = 1'b0;
      loadMaskBit             = 1'b0;
      loadModeReg             = 1'b0;
      clearInternalFF         = 1'b0;
      masterClear             = 1'b0;
      readTemporaryReg        = 1'b0;
      clearMaskReg            = 1'b0;
      loadAllMask             = 1'b0;
      loadBaseAddressReg      = 1'b0;
      loadBaseWordCountReg    = 1'b0;
      readCurrentAddressReg   = 1'b0;
      readCurrentWordCountReg = 1'b0;
      if (wr) begin
         if (!A[3]) begin
            loadBaseAddressReg   = ~A[0];
            loadBaseWordCountReg =  A[0];
         end else begin
            case (A[2:0])
               3'b000:  loadCommandReg  = 1'b1;
               3'b001:  loadRequestReg  = 1'b1;
               3'b010:  loadMaskBit     = 1'b1;
               3'b011:  loadModeReg     = 1'b1;
               3'b100:  clearInternalFF = 1'b1;
               3'b101:  masterClear     = 1'b1;
               3'b110:  clearMaskReg    = 1'b1;
               default: loadAllMask     = 1'b1;
            endcase
         end
      end else if (rd) begin
         if (!A[3]) begin
            readCurrentAddressReg   = ~A[0];
            readCurrentWordCountReg =  A[0];
         end else begin
            case (A[2:0])
               3'b000:  readStatusReg = 1'b1;
`ifdef TEMP_READ_EN
               3'b101:  readTemporaryReg = 1'b1;
`endif
               default: ;
            endcase
         end
      end
   end

   // The pointer toggles on the edge closing the first cycle after a channel access,
   // so a multi-cycle strobe counts once; a clear takes priority.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         internal_ff_reg <= 1'b0;
         access_seen_reg <= 1'b0;
         status_read_reg <= 1'b0;
      end else begin
         status_read_reg <= readStatusReg;
         access_seen_reg <= low_access;
         if (clearInternalFF | masterClear)
            internal_ff_reg <= 1'b0;
         else if (access_seen_reg & ~low_access)
            internal_ff_reg <= ~internal_ff_reg;
      end
   end

   assign internalFF                 = internal_ff_reg;
   assign loadIoDataBufferFromStatus = status_read_reg;

endmodule

// File: tb/tb_reference_model.sv
// Randomized bench for reference_model against a table-driven behavioural model,
// with directed scenarios pinned by literal expectations.
module tb_reference_model;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       CS_N = 1'b1;
   logic       IOR_N = 1'b1;
   logic       IOW_N = 1'b1;
   logic [3:0] A = 4'd0;
   logic       programCondition = 1'b0;

   logic loadCommandReg, readStatusReg, loadRequestReg, loadMaskBit, loadModeReg;
   logic clearInternalFF, masterClear, readTemporaryReg, clearMaskReg, loadAllMask;
   logic loadBaseAddressReg, loadBaseWordCountReg, readCurrentAddressReg, readCurrentWordCountReg;
   logic [1:0] channelSel;
   logic internalFF, loadIoDataBufferFromStatus, accessError;

   reference_model dut (
      .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A),
      .programCondition(programCondition),
      .loadCommandReg(loadCommandReg), .readStatusReg(readStatusReg),
      .loadRequestReg(loadRequestReg), .loadMaskBit(loadMaskBit), .loadModeReg(loadModeReg),
      .clearInternalFF(clearInternalFF), .masterClear(masterClear),
      .readTemporaryReg(readTemporaryReg), .clearMaskReg(clearMaskReg),
      .loadAllMask(loadAllMask), .loadBaseAddressReg(loadBaseAddressReg),
      .loadBaseWordCountReg(loadBaseWordCountReg),
      .readCurrentAddressReg(readCurrentAddressReg),
      .readCurrentWordCountReg(readCurrentWordCountReg),
      .channelSel(channelSel), .internalFF(internalFF),
      .loadIoDataBufferFromStatus(loadIoDataBufferFromStatus), .accessError(accessError)
   );

   always #5 CLK = ~CLK;

   // bit n of dec is decode output n in the order of the map tables below
   logic [13:0] dec;
   assign dec = {readCurrentWordCountReg, readCurrentAddressReg, loadBaseWordCountReg,
                 loadBaseAddressReg, loadAllMask, clearMaskReg, readTemporaryReg,
                 masterClear, clearInternalFF, loadModeReg, loadMaskBit, loadRequestReg,
                 readStatusReg, loadCommandReg};

   int wr_map [16];
   int rd_map [16];
   int vectors = 0;
   int miscompares = 0;
   logic m_ff = 1'b0, m_buf = 1'b0, m_in_access = 1'b0;

   function automatic int exp_idx();
      logic sel;
      sel = RESET_N && programCondition && !CS_N;
      if (sel && !IOW_N && IOR_N) return wr_map[A];
      if (sel && !IOR_N && IOW_N) return rd_map[A];
      return -1;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (A=%b rst_n=%b)", name, act, exp, A, RESET_N);
      end
   endtask

   task automatic model_step();
      int idx;
      logic chan_access;
      idx = exp_idx();
      chan_access = (idx >= 10);
      if (!RESET_N) begin
         m_ff = 1'b0; m_buf = 1'b0; m_in_access = 1'b0;
      end else begin
         m_buf = (idx == 1);
         if (idx == 5 || idx == 6) m_ff = 1'b0;
         else if (m_in_access && !chan_access) m_ff = ~m_ff;
         m_in_access = chan_access;
      end
   endtask

   // One clock cycle: advance the model past the edge, drive new inputs, compare at negedge.
   task automatic cyc(input logic rst_n, input logic pc, input logic cs, input logic ior,
                      input logic iow, input logic [3:0] addr);
      int idx;
      logic [13:0] edec;
      @(posedge CLK);
      model_step();
      #1;
      RESET_N = rst_n; programCondition = pc; CS_N = cs; IOR_N = ior; IOW_N = iow; A = addr;
      @(negedge CLK);
      idx = exp_idx();
      edec = (idx >= 0) ? (14'd1 << idx) : 14'd0;
      check("decode", {2'b0, dec}, {2'b0, edec});
      check("channelSel", {14'b0, channelSel}, {14'b0, (addr[3] ? 2'b00 : addr[2:1])});
      check("accessError", {15'b0, accessError},
            {15'b0, rst_n & pc & ~cs & ~ior & ~iow});
      check("internalFF", {15'b0, internalFF}, {15'b0, m_ff});
      check("ioBufFromStatus", {15'b0, loadIoDataBufferFromStatus}, {15'b0, m_buf});
      $display("cyc rst_n=%b pc=%b cs_n=%b ior_n=%b iow_n=%b A=%b dec=%h ff=%b err=%b",
               rst_n, pc, cs, ior, iow, addr, dec, internalFF, accessError);
   endtask

   task automatic idle();
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         wr_map[i] = -1;
         rd_map[i] = -1;
      end
      for (int i = 0; i < 8; i++) begin
         wr_map[i] = (i % 2 == 0) ? 10 : 11;
         rd_map[i] = (i % 2 == 0) ? 12 : 13;
      end
      wr_map[8] = 0; wr_map[9] = 2; wr_map[10] = 3; wr_map[11] = 4;
      wr_map[12] = 5; wr_map[13] = 6; wr_map[14] = 8; wr_map[15] = 9;
      rd_map[8] = 1;
`ifdef TEMP_READ_EN
      rd_map[13] = 7;
`endif

      // reset state, even with a write presented
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000);
      check("reset decode", {2'b0, dec}, 16'd0);
      check("reset ff", {15'b0, internalFF}, 16'd0);
      idle();

      // command write
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000);
      check("lit loadCommandReg", {2'b0, dec}, 16'h0001);
      // status read then buffer load one cycle later
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000);
      check("lit readStatusReg", {15'b0, readStatusReg}, 16'd1);
      idle();
      check("lit ioBuf", {15'b0, loadIoDataBufferFromStatus}, 16'd1);

      // base address writes to channel 2, pointer toggles once per access
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);
      check("lit chan", {14'b0, channelSel}, 16'd2);
      check("lit loadBaseAddr", {15'b0, loadBaseAddressReg}, 16'd1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);
      idle(); idle();
      check("lit ff after 1st", {15'b0, internalFF}, 16'd1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);
      idle(); idle();
      check("lit ff after 2nd", {15'b0, internalFF}, 16'd0);

      // clear via clearInternalFF and via masterClear
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011);
      idle(); idle();
      check("lit ff set", {15'b0, internalFF}, 16'd1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100);
      idle();
      check("lit ff clr", {15'b0, internalFF}, 16'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
      idle(); idle();
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101);
      idle();
      check("lit ff mclr", {15'b0, internalFF}, 16'd0);

      // both strobes low: error only, pointer unchanged
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      check("lit accessError", {15'b0, accessError}, 16'd1);
      check("lit err decode", {2'b0, dec}, 16'd0);
      idle(); idle();
      check("lit err ff", {15'b0, internalFF}, 16'd0);

      // not in program mode
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1011);
      check("lit pc0 decode", {2'b0, dec}, 16'd0);
      // reset during a channel access aborts the toggle
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
      idle(); idle();
      check("lit reset abort ff", {15'b0, internalFF}, 16'd0);

      // randomized traffic with multi-cycle holds and idle gaps
      for (int n = 0; n < 1200; n++) begin
         logic r, p, c, ir, iw;
         logic [3:0] ad;
         int mode, hold;
         r = ($urandom_range(0, 39) != 0);
         p = ($urandom_range(0, 9) != 0);
         c = ($urandom_range(0, 7) == 0);
         mode = $urandom_range(0, 9);
         ir = !(mode == 0 || (mode >= 1 && mode <= 4));
         iw = !(mode == 0 || (mode >= 5 && mode <= 8));
         ad = 4'($urandom_range(0, 15));
         hold = $urandom_range(1, 3);
         for (int h = 0; h < hold; h++) cyc(r, p, c, ir, iw, ad);
         if ($urandom_range(0, 2) == 0) idle();
      end
      idle(); idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reference_model.md
REFERENCE_MODEL -- requirements
Module: reference_model

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 RESET_N  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-003 CS_N  input  1  chip select, active low.
REQ-004 IOR_N  input  1  I/O read strobe, active low.
REQ-005 IOW_N  input  1  I/O write strobe, active low.
REQ-006 A  input  4  register address (A3..A0).
REQ-007 programCondition  input  1  high = controller in program (CPU-access) mode; all decodes gated by it.
REQ-008 Decode outputs, each 1 bit: loadCommandReg, readStatusReg, loadRequestReg, loadMaskBit, loadModeReg, clearInternalFF, masterClear, readTemporaryReg, clearMaskReg, loadAllMask, loadBaseAddressReg, loadBaseWordCountReg, readCurrentAddressReg, readCurrentWordCountReg.
REQ-009 channelSel  output  2  equals A[2:1] when A3=0, else 0.
REQ-010 internalFF  output  1  byte-pointer flip-flop model; 0 = low byte, 1 = high byte.
REQ-011 loadIoDataBufferFromStatus  output  1  readStatusReg delayed one CLK.
REQ-012 accessError  output  1  high when access=1 with both IOR_N and IOW_N low.

Function
REQ-013 rd = programCondition & !CS_N & !IOR_N & IOW_N; wr = programCondition & !CS_N & !IOW_N & IOR_N; all decodes combinational, zero latency.
REQ-014 A3=0 writes: A0=0 -> loadBaseAddressReg; A0=1 -> loadBaseWordCountReg.
REQ-015 A3=0 reads: A0=0 -> readCurrentAddressReg; A0=1 -> readCurrentWordCountReg.
REQ-016 A=1000: wr -> loadCommandReg, rd -> readStatusReg.
REQ-017 A=1001 wr -> loadRequestReg; 1010 wr -> loadMaskBit; 1011 wr -> loadModeReg; 1100 wr -> clearInternalFF; 1101 wr -> masterClear, rd -> readTemporaryReg; 1110 wr -> clearMaskReg; 1111 wr -> loadAllMask.
REQ-018 Reads of 1001-1100, 1110, 1111 are undefined: no output asserted.
REQ-019 At most one decode output high in any cycle (one-hot or zero).
REQ-020 Both IOR_N and IOW_N low: no decode asserted, accessError=1.
REQ-021 programCondition=0 or CS_N=1: all decodes 0, internalFF held.
REQ-022 internalFF: cleared next edge on clearInternalFF or masterClear; else toggles on the first edge after an A3=0 access (rd or wr) ends, once per access regardless of access length.
REQ-023 A3=0 access active on the same edge as clearInternalFF impossible (distinct addresses); clear has priority over toggle.
REQ-024 loadIoDataBufferFromStatus = readStatusReg registered one cycle.

Reset
REQ-025 RESET_N=0 at rising CLK: internalFF=0, loadIoDataBufferFromStatus=0, access-tracking state=0.
REQ-026 While RESET_N=0 all decode outputs and accessError forced 0.
REQ-027 Reset mid-access aborts it; no internalFF toggle occurs for that access.

Configuration
REQ-028 Macro TEMP_READ_EN: defined -> readTemporaryReg decoded per REQ-017; undefined -> readTemporaryReg tied 0 and rd at 1101 asserts nothing.

Verification
REQ-029 programCondition=1, CS_N=0, IOW_N=0, A=1000 -> loadCommandReg=1 same cycle, others 0.
REQ-030 rd at A=1000 for 1 cycle -> readStatusReg=1, loadIoDataBufferFromStatus=1 next cycle.
REQ-031 wr A=0100 (2 cycles) then wr A=0100 -> loadBaseAddressReg=1, channelSel=2; internalFF 0->1->0 after each access ends.
REQ-032 internalFF=1, wr A=1100 -> internalFF=0 next edge; wr A=1101 also clears it.
REQ-033 IOR_N=IOW_N=0, A=0000 -> accessError=1, no decode, internalFF unchanged.
REQ-034 programCondition=0, wr A=1011 -> loadModeReg=0; RESET_N=0 during A=0001 access -> internalFF=0, no toggle.
